// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the two-port memory arbiter.
// Consumed by mem_arb_pick and mem_arbiter.
package mem_arb_pkg;

    localparam int DEF_WORD_SIZE = 16;
    localparam int DEF_MEM_DEPTH = 21;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_RESP   = 2'd2
    } state_t;

    typedef enum logic {
        SEL_IF = 1'b0,
        SEL_D  = 1'b1
    } sel_t;

endpackage

// File: rtl/mem_arb_pick.sv
// Winner selection between the fetch and data ports.
// With RR_EN=0 the data port always wins a tie; otherwise the port not granted last wins.
module mem_arb_pick
    import mem_arb_pkg::*;
#(
    parameter bit RR_EN = 1'b0
) (
    input  logic if_req_i,
    input  logic d_req_i,
    input  sel_t last_grant_i,
    output sel_t sel_o
);

    always_comb begin
        sel_o = SEL_D;
        if (if_req_i && !d_req_i) begin
            sel_o = SEL_IF;
        end else if (if_req_i && d_req_i && RR_EN && (last_grant_i == SEL_D)) begin
            sel_o = SEL_IF;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Two-port (fetch/data) arbiter in front of a single-port combinational-read memory.
// Define MEM_ARB_RR_EN for round-robin tie-breaking; default is fixed data-over-fetch priority.
//
// state  | meaning
// IDLE   | no access in flight; arbitrate incoming requests
// ACCESS | drive the memory for the latched request
// RESP   | pulse the granted port's ACK; arbitrate again
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WORD_SIZE = DEF_WORD_SIZE,
    parameter int MEM_DEPTH = DEF_MEM_DEPTH
) (
    input  logic                 CLK,
    input  logic                 RST,
    input  logic                 IF_REQ,
    input  logic [WORD_SIZE-1:0] IF_ADDR,
    output logic                 IF_ACK,
    output logic [WORD_SIZE-1:0] IF_DATA,
    input  logic                 D_REQ,
    input  logic                 D_WE,
    input  logic [WORD_SIZE-1:0] D_ADDR,
    input  logic [WORD_SIZE-1:0] D_WDATA,
    output logic                 D_ACK,
    output logic [WORD_SIZE-1:0] D_RDATA,
    output logic                 D_ERR,
    output logic                 MEM_ON,
    output logic                 MEM_W,
    output logic [WORD_SIZE-1:0] MEM_ADDR,
    output logic [WORD_SIZE-1:0] MEM_DIN,
    input  logic [WORD_SIZE-1:0] MEM_DOUT
);

    localparam logic [WORD_SIZE-1:0] DEPTH_W = WORD_SIZE'(MEM_DEPTH);

    state_t               state_q;
    sel_t                 sel_q;
    logic                 we_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic                 if_ack_q;
    logic                 d_ack_q;
    logic                 d_err_q;
    logic [WORD_SIZE-1:0] if_data_q;
    logic [WORD_SIZE-1:0] d_rdata_q;

    sel_t                 pick_sel;
    sel_t                 last_grant;
    logic                 grant;
    logic                 in_range;
    logic [WORD_SIZE-1:0] rd_data_d;

    assign grant     = (state_q != ST_ACCESS) && (IF_REQ || D_REQ);
    assign in_range  = (addr_q < DEPTH_W);
    assign rd_data_d = in_range ? MEM_DOUT : '0;

`ifdef MEM_ARB_RR_EN
    localparam bit RR = 1'b1;
    sel_t last_q;

    always_ff @(posedge CLK) begin
        if (RST) begin
            last_q <= SEL_IF;
        end else if (grant) begin
            last_q <= pick_sel;
        end
    end

    assign last_grant = last_q;
`else
    localparam bit RR = 1'b0;
    assign last_grant = SEL_IF;
`endif

    mem_arb_pick #(
        .RR_EN(RR)
    ) u_pick (
        .if_req_i    (IF_REQ),
        .d_req_i     (D_REQ),
        .last_grant_i(last_grant),
        .sel_o       (pick_sel)
    );

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_IDLE;
            sel_q     <= SEL_IF;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            if_ack_q  <= 1'b0;
            d_ack_q   <= 1'b0;
            d_err_q   <= 1'b0;
            if_data_q <= '0;
            d_rdata_q <= '0;
        end else begin
            if_ack_q <= 1'b0;
            d_ack_q  <= 1'b0;
            d_err_q  <= 1'b0;
            case (state_q)
                ST_ACCESS: begin
                    state_q <= ST_RESP;
                    if (sel_q == SEL_D) begin
                        d_ack_q <= 1'b1;
                        d_err_q <= !in_range;
                        if (!we_q) begin
                            d_rdata_q <= rd_data_d;
                        end
                    end else begin
                        if_ack_q  <= 1'b1;
                        if_data_q <= rd_data_d;
                    end
                end
                default: begin
                    if (grant) begin
                        state_q <= ST_ACCESS;
                        sel_q   <= pick_sel;
                        // Fetches never write; write data only tracks the data port.
                        if (pick_sel == SEL_D) begin
                            addr_q  <= D_ADDR;
                            wdata_q <= D_WDATA;
                            we_q    <= D_WE;
                        end else begin
                            addr_q <= IF_ADDR;
                            we_q   <= 1'b0;
                        end
                    end else begin
                        state_q <= ST_IDLE;
                    end
                end
            endcase
        end
    end

    // Gated by RST combinationally so a reset mid-ACCESS suppresses the write.
    assign MEM_ON   = (state_q == ST_ACCESS) && in_range && !RST;
    assign MEM_W    = MEM_ON && we_q;
    assign MEM_ADDR = addr_q;
    assign MEM_DIN  = wdata_q;

    assign IF_ACK  = if_ack_q;
    assign IF_DATA = if_data_q;
    assign D_ACK   = d_ack_q;
    assign D_RDATA = d_rdata_q;
    assign D_ERR   = d_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: behavioural memory, vector table, scoreboard of responses.
module tb_mem_arbiter;

    logic        CLK = 1'b0;
    logic        RST;
    logic        IF_REQ, D_REQ, D_WE;
    logic [15:0] IF_ADDR, D_ADDR, D_WDATA;
    logic        IF_ACK, D_ACK, D_ERR, MEM_ON, MEM_W;
    logic [15:0] IF_DATA, D_RDATA, MEM_ADDR, MEM_DIN, MEM_DOUT;

    logic [15:0] mem [0:31];

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic        is_d;
        logic        we;
        logic [15:0] addr;
        logic [15:0] wdata;
        logic [15:0] exp_data;
        logic        exp_err;
        logic        chk_data;
    } vec_t;

    typedef struct {
        logic        is_d;
        logic [15:0] data;
        logic        err;
        logic        chk_data;
    } exp_t;

    exp_t sbq [$];

    always #5 CLK = ~CLK;

    mem_arbiter dut (
        .CLK(CLK), .RST(RST),
        .IF_REQ(IF_REQ), .IF_ADDR(IF_ADDR), .IF_ACK(IF_ACK), .IF_DATA(IF_DATA),
        .D_REQ(D_REQ), .D_WE(D_WE), .D_ADDR(D_ADDR), .D_WDATA(D_WDATA),
        .D_ACK(D_ACK), .D_RDATA(D_RDATA), .D_ERR(D_ERR),
        .MEM_ON(MEM_ON), .MEM_W(MEM_W), .MEM_ADDR(MEM_ADDR), .MEM_DIN(MEM_DIN),
        .MEM_DOUT(MEM_DOUT)
    );

    assign MEM_DOUT = (MEM_ADDR < 16'd32) ? mem[MEM_ADDR[4:0]] : 16'hDEAD;

    always @(posedge CLK) begin
        if (MEM_ON && MEM_W && (MEM_ADDR < 16'd32)) mem[MEM_ADDR[4:0]] <= MEM_DIN;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every ACK pops the oldest expected response.
    always @(negedge CLK) begin
        if (IF_ACK === 1'b1 && D_ACK === 1'b1) chk("dual_ack", 1, 0);
        if (D_ERR === 1'b1 && D_ACK !== 1'b1) chk("err_without_ack", 1, 0);
        if (IF_ACK === 1'b1 || D_ACK === 1'b1) begin
            if (sbq.size() == 0) begin
                chk("unexpected_ack", {30'd0, D_ACK, IF_ACK}, 0);
            end else begin
                exp_t e;
                e = sbq.pop_front();
                chk("ack_port", {31'd0, D_ACK}, {31'd0, e.is_d});
                if (e.is_d) begin
                    chk("d_err", {31'd0, D_ERR}, {31'd0, e.err});
                    if (e.chk_data) chk("d_rdata", {16'd0, D_RDATA}, {16'd0, e.data});
                end else if (e.chk_data) begin
                    chk("if_data", {16'd0, IF_DATA}, {16'd0, e.data});
                end
            end
        end
    end

    task automatic do_req(input vec_t v);
        bit got;
        @(negedge CLK);
        if (v.is_d) begin
            D_REQ = 1'b1; D_WE = v.we; D_ADDR = v.addr; D_WDATA = v.wdata;
        end else begin
            IF_REQ = 1'b1; IF_ADDR = v.addr;
        end
        sbq.push_back('{v.is_d, v.exp_data, v.exp_err, v.chk_data});
        got = 1'b0;
        for (int c = 0; c < 20 && !got; c++) begin
            @(negedge CLK);
            if (v.is_d ? (D_ACK === 1'b1) : (IF_ACK === 1'b1)) got = 1'b1;
        end
        IF_REQ = 1'b0;
        D_REQ  = 1'b0;
        chk("req_done", {31'd0, got}, 1);
        if (!got && sbq.size() > 0) void'(sbq.pop_back());
    endtask

    vec_t vt [12];
    bit   g [4];
    int   n;

    initial begin
        for (int i = 0; i < 32; i++) mem[i] = 16'hA000 | 16'(i);
        mem[4]  = 16'h7223;
        mem[21] = 16'hDEAD;

        vt[0]  = '{1'b1, 1'b1, 16'd16, 16'hBEEF, 16'h0000, 1'b0, 1'b0};
        vt[1]  = '{1'b1, 1'b0, 16'd16, 16'h0000, 16'hBEEF, 1'b0, 1'b1};
        vt[2]  = '{1'b1, 1'b1, 16'd21, 16'h1234, 16'h0000, 1'b1, 1'b0};
        vt[3]  = '{1'b1, 1'b0, 16'd21, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vt[4]  = '{1'b0, 1'b0, 16'd21, 16'h0000, 16'h0000, 1'b0, 1'b1};
        vt[5]  = '{1'b0, 1'b0, 16'd16, 16'h0000, 16'hBEEF, 1'b0, 1'b1};
        vt[6]  = '{1'b1, 1'b0, 16'd20, 16'h0000, 16'hA014, 1'b0, 1'b1};
        vt[7]  = '{1'b1, 1'b1, 16'd0,  16'h5555, 16'h0000, 1'b0, 1'b0};
        vt[8]  = '{1'b0, 1'b0, 16'd0,  16'h0000, 16'h5555, 1'b0, 1'b1};
        vt[9]  = '{1'b1, 1'b0, 16'd0,  16'h0000, 16'h5555, 1'b0, 1'b1};
        vt[10] = '{1'b1, 1'b0, 16'hFFFF, 16'h0000, 16'h0000, 1'b1, 1'b1};
        vt[11] = '{1'b0, 1'b0, 16'd20, 16'h0000, 16'hA014, 1'b0, 1'b1};

        RST = 1'b1; IF_REQ = 1'b0; D_REQ = 1'b0; D_WE = 1'b0;
        IF_ADDR = '0; D_ADDR = '0; D_WDATA = '0;
        repeat (3) @(negedge CLK);
        chk("rst_if_ack", {31'd0, IF_ACK}, 0);
        chk("rst_d_ack", {31'd0, D_ACK}, 0);
        chk("rst_d_err", {31'd0, D_ERR}, 0);
        chk("rst_if_data", {16'd0, IF_DATA}, 0);
        chk("rst_d_rdata", {16'd0, D_RDATA}, 0);
        chk("rst_mem_addr", {16'd0, MEM_ADDR}, 0);
        chk("rst_mem_din", {16'd0, MEM_DIN}, 0);
        chk("rst_mem_on", {31'd0, MEM_ON}, 0);
        RST = 1'b0;

        // Fetch latency: MEM_ON in the cycle after the request, ACK the cycle after that.
        @(negedge CLK);
        IF_REQ = 1'b1; IF_ADDR = 16'd4;
        sbq.push_back('{1'b0, 16'h7223, 1'b0, 1'b1});
        @(negedge CLK);
        chk("lat_mem_on", {31'd0, MEM_ON}, 1);
        chk("lat_mem_w", {31'd0, MEM_W}, 0);
        chk("lat_mem_addr", {16'd0, MEM_ADDR}, 4);
        chk("lat_no_ack_yet", {31'd0, IF_ACK}, 0);
        @(negedge CLK);
        chk("lat_if_ack", {31'd0, IF_ACK}, 1);
        chk("lat_if_data", {16'd0, IF_DATA}, 16'h7223);
        IF_REQ = 1'b0;
        @(negedge CLK);
        chk("ack_one_cycle", {31'd0, IF_ACK}, 0);

        for (int i = 0; i < 12; i++) do_req(vt[i]);
        chk("oob_store_mem21", {16'd0, mem[21]}, 16'hDEAD);
        chk("store_mem16", {16'd0, mem[16]}, 16'hBEEF);

        // Both ports held continuously for four grants.
        @(negedge CLK);
        D_WE = 1'b0; D_ADDR = 16'd1; IF_ADDR = 16'd2;
        IF_REQ = 1'b1; D_REQ = 1'b1;
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            sbq.push_back('{(k % 2) == 0, ((k % 2) == 0) ? 16'hA001 : 16'hA002, 1'b0, 1'b1});
`else
            sbq.push_back('{1'b1, 16'hA001, 1'b0, 1'b1});
`endif
        end
        n = 0;
        for (int c = 0; c < 40 && n < 4; c++) begin
            @(negedge CLK);
            if (D_ACK === 1'b1) begin g[n] = 1'b1; n++; end
            else if (IF_ACK === 1'b1) begin g[n] = 1'b0; n++; end
        end
        IF_REQ = 1'b0; D_REQ = 1'b0;
        chk("prio_grants", n, 4);
        for (int k = 0; k < 4; k++) begin
`ifdef MEM_ARB_RR_EN
            chk("prio_order", {31'd0, g[k]}, (k % 2) == 0);
`else
            chk("prio_order", {31'd0, g[k]}, 1);
`endif
        end

        // Reset during a store's ACCESS cycle must kill the write and the ACK.
        @(negedge CLK);
        D_REQ = 1'b1; D_WE = 1'b1; D_ADDR = 16'd5; D_WDATA = 16'h9999;
        @(negedge CLK);
        chk("abort_in_access", {30'd0, MEM_ON, MEM_W}, 2'b11);
        RST = 1'b1; D_REQ = 1'b0;
        #1;
        chk("abort_mem_w", {31'd0, MEM_W}, 0);
        chk("abort_mem_on", {31'd0, MEM_ON}, 0);
        repeat (2) @(negedge CLK);
        RST = 1'b0;
        repeat (3) begin
            @(negedge CLK);
            chk("abort_no_ack", {31'd0, D_ACK}, 0);
        end
        chk("abort_mem5", {16'd0, mem[5]}, 16'hA005);
        do_req('{1'b1, 1'b0, 16'd5, 16'h0000, 16'hA005, 1'b0, 1'b1});

        repeat (3) @(negedge CLK);
        chk("sb_empty", sbq.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter WORD_SIZE, default 16, SHALL set data and address width in bits.
REQ-002 Parameter MEM_DEPTH, default 21, SHALL set the number of valid memory words; valid addresses are 0..MEM_DEPTH-1.
REQ-003 CLK  in  1  SHALL be the single clock; all state updates on posedge CLK.
REQ-004 RST  in  1  SHALL be the reset: synchronous, active-high.
REQ-005 IF_REQ  in  1  SHALL be the instruction-fetch read request.
REQ-006 IF_ADDR  in  WORD_SIZE  SHALL be the fetch address.
REQ-007 IF_ACK  out  1  SHALL be a one-cycle fetch-completion pulse.
REQ-008 IF_DATA  out  WORD_SIZE  SHALL be the fetched word, valid while IF_ACK=1.
REQ-009 D_REQ, D_WE  in  1 each  SHALL be the data-port request and write-enable (1=store, 0=load).
REQ-010 D_ADDR, D_WDATA  in  WORD_SIZE each  SHALL be the data-port address and store data.
REQ-011 D_ACK  out  1; D_RDATA  out  WORD_SIZE; D_ERR  out  1  SHALL be completion pulse, load data and out-of-range flag, valid with D_ACK.
REQ-012 MEM_ON, MEM_W  out  1 each; MEM_ADDR, MEM_DIN  out  WORD_SIZE each  SHALL drive the shared single-port memory's ON, W, ADDR, DATA_IN.
REQ-013 MEM_DOUT  in  WORD_SIZE  SHALL carry the memory's combinational DATA_OUT.

Function
REQ-014 FSM SHALL have states IDLE, ACCESS, RESP.
REQ-015 In IDLE or RESP: if any REQ=1, pick a winner, latch its address/write-data/op, go to ACCESS; else go to IDLE.
REQ-016 In ACCESS: MEM_ON=1, MEM_W=latched op (IF always 0), MEM_ADDR/MEM_DIN=latched values; always go to RESP next.
REQ-017 Outside ACCESS: MEM_ON=0, MEM_W=0, MEM_ADDR and MEM_DIN hold last latched values.
REQ-018 Read data SHALL be registered from MEM_DOUT at the posedge ending ACCESS; store completes at that same edge.
REQ-019 In RESP: exactly the granted port's ACK=1 for one cycle; the other ACK=0.
REQ-020 Latency: REQ seen in cycle N -> ACCESS in N+1 -> ACK in N+2; back-to-back throughput one access per 2 cycles.
REQ-021 Requester SHALL hold REQ until its ACK; arbiter SHALL ignore address/data changes after latch; requester deasserts REQ in the ACK cycle or it is re-arbitrated in that cycle as a new request.
REQ-022 Default priority: D over IF on simultaneous requests.
REQ-023 Latched address >= MEM_DEPTH: MEM_ON held 0 in ACCESS (no store), read data returned as 0, D_ERR=1 with D_ACK; IF out-of-range returns 0 with no error flag.
REQ-024 D_ERR SHALL be 0 whenever D_ACK=0.

Reset
REQ-025 RST=1 at a posedge SHALL force IDLE, all ACKs 0, D_ERR 0, IF_DATA/D_RDATA 0, MEM_ADDR/MEM_DIN 0, priority pointer to IF-last.
REQ-026 MEM_ON and MEM_W SHALL be gated by !RST combinationally so RST asserted during an ACCESS store suppresses that write.
REQ-027 A request aborted by reset SHALL never be acknowledged; it re-arbitrates after RST falls if still asserted.

Configuration
REQ-028 Macro MEM_ARB_RR_EN defined: round-robin priority; on tie grant the port not granted last; pointer updates on every grant.
REQ-029 MEM_ARB_RR_EN undefined: fixed D-over-IF priority per REQ-022; no pointer register.

Structure
REQ-030 Shared package mem_arb_pkg SHALL hold state encoding (IDLE/ACCESS/RESP), port-select encoding (SEL_IF/SEL_D) and default MEM_DEPTH/WORD_SIZE.
REQ-031 Winner selection SHALL be a sub-module mem_arb_pick (inputs two REQs and last-grant, output select).

Verification
REQ-032 Reset then IF_REQ=1, IF_ADDR=4 with memory[4]=16'h7223 -> MEM_ON=1 cycle 1, IF_ACK=1 and IF_DATA=16'h7223 cycle 2.
REQ-033 D_REQ=1, D_WE=1, D_ADDR=16, D_WDATA=16'hBEEF, then load addr 16 -> D_ACK both, D_RDATA=16'hBEEF, D_ERR=0.
REQ-034 IF_REQ and D_REQ held together 4 grants -> default: D,D,D,D; with MEM_ARB_RR_EN: D,IF,D,IF.
REQ-035 D store to D_ADDR=21 -> MEM_ON stays 0, D_ACK=1 with D_ERR=1, memory unchanged; load addr 21 -> D_RDATA=0, D_ERR=1.
REQ-036 Store to addr 5, RST=1 during ACCESS -> MEM_W=0 that cycle, memory[5] unchanged, no D_ACK, FSM IDLE.
